// File: rtl/skolem_witness_search.sv
// skolem_witness_search: for each universal assignment x, searches existential candidates y
// one per cycle. It returns the first y for which o = NOR(cubes over {x, y}) is 1, or reports
// that no y satisfies o.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   x request handshake; in_ready is high only in IDLE
//   in_x[NX-1:0]        universal assignment, in_x[i] = x(i+1)
//   out_valid/out_ready result handshake; result is held while out_ready is low
//   out_y[NY-1:0]       witness, out_y[j] = y(j+1); 0 when unsat
//   out_sat             1 = witness found
//   out_iters[NY:0]     number of candidates evaluated (1..2^NY)
module skolem_witness_search #(
  parameter int unsigned NX     = 3,
  parameter int unsigned NY     = 2,
  parameter int unsigned NTERMS = 3,
  parameter logic [NTERMS*(NX+NY)-1:0] POS_MASK = 15'b00010_11000_00111,
  parameter logic [NTERMS*(NX+NY)-1:0] NEG_MASK = 15'b10001_00010_00000,
  parameter bit          WARM_START = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NX-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NY-1:0] out_y,
  output logic          out_sat,
  output logic [NY:0]   out_iters
);

  localparam int unsigned NV = NX + NY;
  localparam logic [NY:0] NumCand = {1'b1, {NY{1'b0}}};

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e        state_q, state_d;
  logic [NX-1:0] x_q, x_d;
  logic [NY-1:0] cand_q, cand_d;
  logic [NY:0]   cnt_q, cnt_d;
  logic [NY-1:0] last_y_q, last_y_d;
  logic [NY-1:0] out_y_q, out_y_d;
  logic          out_sat_q, out_sat_d;
  logic [NY:0]   out_iters_q, out_iters_d;

  logic [NV-1:0]     lit;
  logic [NTERMS-1:0] cube;
  logic              o;
  logic [NY:0]       cnt_inc;

  assign lit     = {x_q, cand_q};
  assign cnt_inc = cnt_q + (NY+1)'(1);

  // All-zero masks make a cube constant true; overlapping pos/neg bits make it constant false.
  always_comb begin
    cube = '0;
    for (int t = 0; t < NTERMS; t++) begin
      cube[t] = ((lit & POS_MASK[t*NV +: NV]) == POS_MASK[t*NV +: NV]) &&
                ((lit & NEG_MASK[t*NV +: NV]) == '0);
    end
    o = ~|cube;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    last_y_d    = last_y_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;
    out_iters_d = out_iters_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_x;
          cand_d  = WARM_START ? last_y_q : '0;
          cnt_d   = '0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (o) begin
          out_y_d     = cand_q;
          out_sat_d   = 1'b1;
          out_iters_d = cnt_inc;
          last_y_d    = cand_q;
          state_d     = StDone;
        end else if (cnt_inc == NumCand) begin
          // Exhaustion is tracked by cnt so a warm-started search still covers every y once.
          out_y_d     = '0;
          out_sat_d   = 1'b0;
          out_iters_d = NumCand;
          state_d     = StDone;
        end else begin
          cand_d = cand_q + NY'(1);
          cnt_d  = cnt_inc;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      last_y_q    <= '0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
      out_iters_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      last_y_q    <= last_y_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
      out_iters_q <= out_iters_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;
  assign out_iters = out_iters_q;

endmodule

// File: tb/tb_skolem_witness_search.sv
// Bench for skolem_witness_search: three instances (default, warm start, constant-true cube)
// driven by directed and random requests, checked against an integer reference model.
module tb_skolem_witness_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_valid = '0;
  logic [2:0] in_ready;
  logic [2:0] in_x [3];
  logic [2:0] out_valid;
  logic [2:0] out_ready = '0;
  logic [1:0] out_y [3];
  logic [2:0] out_sat;
  logic [2:0] out_iters [3];

  int checks = 0;
  int errors = 0;

  // Reference configuration mirrored as plain integers.
  int nterms_cfg [3] = '{3, 3, 1};
  int pos_cfg    [3] = '{'h0B07, 'h0B07, 0};  // 00010_11000_00111
  int neg_cfg    [3] = '{'h4440, 'h4440, 0};  // 10001_00010_00000
  int warm_cfg   [3] = '{0, 1, 1};
  int last_y     [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  skolem_witness_search u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_x(in_x[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_y(out_y[0]), .out_sat(out_sat[0]),
    .out_iters(out_iters[0])
  );

  skolem_witness_search #(.WARM_START(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_x(in_x[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_y(out_y[1]), .out_sat(out_sat[1]),
    .out_iters(out_iters[1])
  );

  skolem_witness_search #(
    .NTERMS(1), .POS_MASK(5'b0), .NEG_MASK(5'b0), .WARM_START(1'b1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_x(in_x[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_y(out_y[2]), .out_sat(out_sat[2]),
    .out_iters(out_iters[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // o = NOR of cubes over v = x*4 + y, straight from the formula.
  function automatic bit model_o(input int d, input int x, input int y);
    int v;
    int p;
    int n;
    v = x * 4 + y;
    for (int t = 0; t < nterms_cfg[d]; t++) begin
      p = (pos_cfg[d] >> (t * 5)) & 31;
      n = (neg_cfg[d] >> (t * 5)) & 31;
      if (((v & p) == p) && ((v & n) == 0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_search(input int d, input int x, output int y, output int sat,
                              output int iters);
    int start;
    start = (warm_cfg[d] != 0) ? last_y[d] : 0;
    y = 0; sat = 0; iters = 4;
    for (int i = 0; i < 4; i++) begin
      if (model_o(d, x, (start + i) % 4)) begin
        y = (start + i) % 4; sat = 1; iters = i + 1;
        break;
      end
    end
    if (sat != 0) last_y[d] = y;
  endtask

  task automatic release_result(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    check("drop_valid", 32'(out_valid[d]), 32'd0);
    check("ready_again", 32'(in_ready[d]), 32'd1);
  endtask

  // Issue one request; optionally pulse in_valid with a different x during SEARCH.
  task automatic request(input int d, input logic [2:0] x, input bit glitch, input bit rel);
    int ey, es, ei, edges, waits;
    model_search(d, int'(x), ey, es, ei);
    waits = 0;
    while (!in_ready[d] && waits < 20) begin
      @(posedge clk); #1; waits++;
    end
    check("accept_ready", 32'(in_ready[d]), 32'd1);
    in_x[d] = x; in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    edges = 0;
    while (edges < 40) begin
      if (glitch && edges == 0) begin
        in_valid[d] = 1'b1; in_x[d] = ~x;
      end
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      edges++;
      if (out_valid[d]) break;
    end
    check("latency", 32'(edges), 32'(ei));
    check("out_y", 32'(out_y[d]), 32'(ey));
    check("out_sat", 32'(out_sat[d]), 32'(es));
    check("out_iters", 32'(out_iters[d]), 32'(ei));
    if (rel) release_result(d);
  endtask

  initial begin
    logic [1:0] hold_y;
    logic [2:0] hold_it;
    logic       hold_sat;
    for (int d = 0; d < 3; d++) in_x[d] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_valid", 32'(out_valid[d]), 32'd0);
      check("rst_ready", 32'(in_ready[d]), 32'd1);
      check("rst_y", 32'(out_y[d]), 32'd0);
      check("rst_iters", 32'(out_iters[d]), 32'd0);
    end

    // Directed cases from the plan.
    request(0, 3'b000, 1'b0, 1'b1);
    request(0, 3'b110, 1'b1, 1'b1);
    request(1, 3'b110, 1'b0, 1'b1);
    request(1, 3'b000, 1'b0, 1'b1);
    request(1, 3'b111, 1'b0, 1'b1);
    request(2, 3'b101, 1'b0, 1'b1);

    // Backpressure: result must hold while a foreign request is ignored.
    request(0, 3'b110, 1'b0, 1'b0);
    hold_y = out_y[0]; hold_it = out_iters[0]; hold_sat = out_sat[0];
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = (c == 2); in_x[0] = 3'b001;
      @(posedge clk); #1;
      check("bp_valid", 32'(out_valid[0]), 32'd1);
      check("bp_ready", 32'(in_ready[0]), 32'd0);
      check("bp_y", 32'(out_y[0]), 32'(hold_y));
      check("bp_iters", 32'(out_iters[0]), 32'(hold_it));
      check("bp_sat", 32'(out_sat[0]), 32'(hold_sat));
    end
    in_valid[0] = 1'b0;
    release_result(0);
    request(0, 3'b110, 1'b0, 1'b1);

    // Random requests on all instances.
    for (int i = 0; i < 24; i++) begin
      request(i % 3, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset in the middle of an unsat search on instance 2.
    in_x[2] = 3'b011; in_valid[2] = 1'b1;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid[2]), 32'd0);
    check("arst_sat", 32'(out_sat[2]), 32'd0);
    check("arst_y", 32'(out_y[2]), 32'd0);
    check("arst_iters", 32'(out_iters[2]), 32'd0);
    for (int d = 0; d < 3; d++) last_y[d] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("post_rst_valid", 32'(out_valid[2]), 32'd0);
      check("post_rst_ready", 32'(in_ready[2]), 32'd1);
    end
    // Warm start must begin from y=0 again after reset.
    request(1, 3'b000, 1'b0, 1'b1);
    request(1, 3'b110, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
